apuf_crp_sequencer: RTL and testbench
=====================================

Name: apuf_crp_sequencer

Overview:
- Controller that drives the challenge bus of an arbiter-PUF array and collects its 1-bit response.
- Generates challenges from a seeded LFSR and waits a programmable settle time per challenge.
- Majority-votes repeated samples into one response bit, packs bits into words and hands them out over a valid/ready interface.
- Sits between the PUF array (combinational Chal -> out_Q) and the host/enrolment logic.

Parameters:
- CHAL_W, 243, challenge width driven to the PUF array.
- SETTLE_CYC, 4, cycles held per challenge before sampling; must be >= 1.
- VOTE_N, 5, samples per challenge for majority vote; odd, >= 1.
- RESP_W, 32, response bits packed per output word.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle start pulse; honoured only in IDLE.
- seed_i  in  CHAL_W  LFSR seed, captured on an accepted start.
- num_words_i  in  16  words to produce, captured on an accepted start.
- chal_o  out  CHAL_W  challenge to the PUF array.
- puf_resp_i  in  1  PUF array response (out_Q).
- resp_word_o  out  RESP_W  packed response word.
- resp_valid_o  out  1  resp_word_o valid.
- resp_ready_i  in  1  consumer accepts the word.
- busy_o  out  1  high whenever state != IDLE.
- done_o  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- States: IDLE, SETTLE, SAMPLE, EMIT, DONE.
- IDLE:
  - On start_i=1 with num_words_i != 0: chal_o <= seed_i, or CHAL_W'h1 if seed_i == 0 (avoids LFSR lockup). Capture num_words_i. Clear bit index and vote count. Go to SETTLE.
  - On start_i=1 with num_words_i == 0: go to DONE.
- SETTLE: hold chal_o for exactly SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE: sample puf_resp_i on each of VOTE_N consecutive edges and count ones. On the last sample edge:
  - bit = (ones_total > VOTE_N/2).
  - Write bit into resp_word_o[bit_idx]; bit 0 is filled first.
  - Advance the LFSR: fb = chal[CHAL_W-1] ^ chal[CHAL_W/2] ^ chal[0]; chal_o <= {chal_o[CHAL_W-2:0], fb}.
  - Clear the vote count.
  - If bit_idx == RESP_W-1: bit_idx <= 0, resp_valid_o <= 1, go to EMIT. Otherwise bit_idx++ and go to SETTLE.
- Per-bit cost is SETTLE_CYC + VOTE_N cycles. First resp_valid_o is asserted RESP_W*(SETTLE_CYC+VOTE_N) cycles after the start edge (288 cycles at defaults).
- EMIT:
  - resp_word_o and resp_valid_o are held stable until resp_ready_i=1; valid is never withdrawn early.
  - On handshake: resp_valid_o <= 0, words_left--.
  - If words_left reaches 0, go to DONE; otherwise go to SETTLE with the already-advanced challenge.
  - resp_ready_i asserted ahead of valid completes the handshake in the first EMIT cycle.
- DONE: done_o = 1 for one cycle, then IDLE. chal_o keeps its last value.
- start_i is ignored while busy_o=1.
- rst mid-run: next edge returns everything to reset values; any partial word is discarded.
- Bit index wraps RESP_W-1 -> 0. words_left is 16-bit unsigned, and 0 at start means no work.

Optional Feature:
- Macro APUF_CRP_STABILITY_EN.
- When defined: adds output unstable_cnt_o (16 bits, reset 0, cleared on accepted start). It increments once per response bit whose VOTE_N samples were not unanimous, and saturates at 16'hFFFF.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

Test Plan:
- Common bench config: CHAL_W=8, SETTLE_CYC=2, VOTE_N=3, RESP_W=4, PUF model puf_resp_i = chal_o[1].
- Seed 8'h01, num_words=1, ready=1 -> challenges 01,03,07,0F; resp_word_o=4'hE; valid rises 20 cycles after start edge; done_o pulses 1 cycle after handshake.
- Seed 8'h00 -> first chal_o=8'h01; output identical to the previous test.
- num_words=2, ready held low 10 cycles at the first EMIT -> word and valid stable through the stall; second word follows; exactly two handshakes, then done.
- num_words=0 -> busy_o high 1 cycle, done_o pulse, no resp_valid_o.
- PUF model returns 1,0,1 per vote window (APUF_CRP_STABILITY_EN defined) -> every bit 1; unstable_cnt_o=4 after one word.
- rst asserted mid-SAMPLE, then start reissued -> outputs 0 after the reset edge; new run output matches the first test.

Source files
------------

// File: rtl/apuf_crp_sequencer.sv
// apuf_crp_sequencer
//   Drives the challenge bus of an arbiter-PUF array from a seeded LFSR. Each
//   challenge is held for SETTLE_CYC cycles and then sampled VOTE_N times. The
//   majority of those samples becomes one response bit. RESP_W bits are packed
//   per word, and the word is handed out over a valid/ready interface.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   start_i         start pulse, honoured only in IDLE
//   seed_i          LFSR seed, captured on an accepted start (0 is replaced by 1)
//   num_words_i     number of words to produce, captured on an accepted start
//   chal_o          challenge to the PUF array
//   puf_resp_i      PUF array response bit
//   resp_word_o     packed response word
//   resp_valid_o    resp_word_o valid
//   resp_ready_i    consumer accepts resp_word_o
//   busy_o          high whenever the FSM is not in IDLE
//   done_o          one-cycle pulse at the end of a run
//   unstable_cnt_o  (APUF_CRP_STABILITY_EN only) count of non-unanimous bits
//
// Handshake: a word transfers on a rising clk edge where resp_valid_o and
// resp_ready_i are both high. Once raised, resp_valid_o and resp_word_o stay
// stable until that edge. The ready signal may be high before valid.
//
// Optional feature macro: APUF_CRP_STABILITY_EN
module apuf_crp_sequencer #(
  parameter int CHAL_W     = 243,
  parameter int SETTLE_CYC = 4,
  parameter int VOTE_N     = 5,
  parameter int RESP_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [CHAL_W-1:0] seed_i,
  input  logic [15:0]       num_words_i,
  output logic [CHAL_W-1:0] chal_o,
  input  logic              puf_resp_i,
  output logic [RESP_W-1:0] resp_word_o,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic              busy_o,
  output logic              done_o
`ifdef APUF_CRP_STABILITY_EN
  ,
  output logic [15:0]       unstable_cnt_o
`endif
);

  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int VC_W = $clog2(VOTE_N + 1);
  localparam int BI_W = (RESP_W > 1) ? $clog2(RESP_W) : 1;

  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYC - 1);
  localparam logic [VC_W-1:0] VOTE_LAST   = VC_W'(VOTE_N - 1);
  localparam logic [VC_W-1:0] VOTE_HALF   = VC_W'(VOTE_N / 2);
  localparam logic [VC_W-1:0] VOTE_ALL    = VC_W'(VOTE_N);
  localparam logic [BI_W-1:0] BIT_LAST    = BI_W'(RESP_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_SAMPLE, S_EMIT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CHAL_W-1:0]   chal_q, chal_d;
  logic [RESP_W-1:0]   word_q, word_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [SC_W-1:0]     settle_cnt_q, settle_cnt_d;
  logic [VC_W-1:0]     vote_cnt_q, vote_cnt_d;
  logic [VC_W-1:0]     ones_q, ones_d;
  logic [BI_W-1:0]     bit_idx_q, bit_idx_d;
  logic [15:0]         words_left_q, words_left_d;
  logic [15:0]         unstable_q, unstable_d;

  // Ones count including the sample taken on the current edge.
  logic [VC_W-1:0]     ones_total;
  logic                lfsr_fb;

  assign ones_total = ones_q + VC_W'(puf_resp_i);
  assign lfsr_fb    = chal_q[CHAL_W-1] ^ chal_q[CHAL_W/2] ^ chal_q[0];

  always_comb begin
    state_d      = state_q;
    chal_d       = chal_q;
    word_d       = word_q;
    valid_d      = valid_q;
    settle_cnt_d = settle_cnt_q;
    vote_cnt_d   = vote_cnt_q;
    ones_d       = ones_q;
    bit_idx_d    = bit_idx_q;
    words_left_d = words_left_q;
    unstable_d   = unstable_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (num_words_i != 16'd0) begin
            // An all-zero seed would lock the LFSR, so it is replaced by 1.
            chal_d       = (seed_i == '0) ? CHAL_W'(1) : seed_i;
            words_left_d = num_words_i;
            bit_idx_d    = '0;
            vote_cnt_d   = '0;
            ones_d       = '0;
            settle_cnt_d = '0;
            unstable_d   = '0;
            state_d      = S_SETTLE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          settle_cnt_d = '0;
          state_d      = S_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        if (vote_cnt_q == VOTE_LAST) begin
          word_d[bit_idx_q] = (ones_total > VOTE_HALF);
          chal_d     = {chal_q[CHAL_W-2:0], lfsr_fb};
          vote_cnt_d = '0;
          ones_d     = '0;
          if ((ones_total != '0) && (ones_total != VOTE_ALL) &&
              (unstable_q != 16'hFFFF)) begin
            unstable_d = unstable_q + 16'd1;
          end
          if (bit_idx_q == BIT_LAST) begin
            bit_idx_d = '0;
            valid_d   = 1'b1;
            state_d   = S_EMIT;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            state_d   = S_SETTLE;
          end
        end else begin
          vote_cnt_d = vote_cnt_q + 1'b1;
          ones_d     = ones_total;
        end
      end
      S_EMIT: begin
        if (resp_ready_i) begin
          valid_d      = 1'b0;
          words_left_d = words_left_q - 16'd1;
          // The challenge was already advanced on the last sample edge.
          state_d      = (words_left_q == 16'd1) ? S_DONE : S_SETTLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered copies of the next-state decode.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      chal_q       <= '0;
      word_q       <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      settle_cnt_q <= '0;
      vote_cnt_q   <= '0;
      ones_q       <= '0;
      bit_idx_q    <= '0;
      words_left_q <= '0;
      unstable_q   <= '0;
    end else begin
      state_q      <= state_d;
      chal_q       <= chal_d;
      word_q       <= word_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      settle_cnt_q <= settle_cnt_d;
      vote_cnt_q   <= vote_cnt_d;
      ones_q       <= ones_d;
      bit_idx_q    <= bit_idx_d;
      words_left_q <= words_left_d;
      unstable_q   <= unstable_d;
    end
  end

  assign chal_o       = chal_q;
  assign resp_word_o  = word_q;
  assign resp_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

`ifdef APUF_CRP_STABILITY_EN
  assign unstable_cnt_o = unstable_q;
`else
  // Without the stability feature the counter has no observer.
  logic unused_unstable;
  assign unused_unstable = ^unstable_q;
`endif

endmodule

// File: tb/tb_apuf_crp_sequencer.sv
// Bench for apuf_crp_sequencer with CHAL_W=8, SETTLE_CYC=2, VOTE_N=3, RESP_W=4.
// By default the PUF model is puf_resp_i = chal_o[1]. The bench can override it
// with a directed sample pattern.
module tb_apuf_crp_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic [7:0] seed_i = 8'h00;
  logic [15:0] num_words_i = 16'd0;
  logic [7:0] chal_o;
  logic       puf_resp_i;
  logic [3:0] resp_word_o;
  logic       resp_valid_o;
  logic       resp_ready_i = 1'b0;
  logic       busy_o;
  logic       done_o;
`ifdef APUF_CRP_STABILITY_EN
  logic [15:0] unstable_cnt_o;
`endif

  logic puf_ovr = 1'b0;
  logic puf_drv = 1'b0;
  assign puf_resp_i = puf_ovr ? puf_drv : chal_o[1];

  apuf_crp_sequencer #(
    .CHAL_W(8), .SETTLE_CYC(2), .VOTE_N(3), .RESP_W(4)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .seed_i(seed_i),
    .num_words_i(num_words_i), .chal_o(chal_o), .puf_resp_i(puf_resp_i),
    .resp_word_o(resp_word_o), .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i), .busy_o(busy_o), .done_o(done_o)
`ifdef APUF_CRP_STABILITY_EN
    , .unstable_cnt_o(unstable_cnt_o)
`endif
  );

  // Clock and reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  logic [3:0] exp_q[$];
  logic [7:0] mdl_chal;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference LFSR and PUF model: one word from the current model challenge.
  task automatic model_word(output logic [3:0] w);
    for (int i = 0; i < 4; i++) begin
      w[i]     = mdl_chal[1];
      mdl_chal = {mdl_chal[6:0], mdl_chal[7] ^ mdl_chal[4] ^ mdl_chal[0]};
    end
  endtask

  // Inputs change only #1 after posedge. A valid&&ready seen at negedge
  // therefore completes on the following posedge.
  always @(negedge clk) begin
    if (!rst && resp_valid_o && resp_ready_i) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_word", {28'd0, resp_word_o}, 32'hFFFF_FFFF);
      end else begin
        check("resp_word", {28'd0, resp_word_o}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] seed, input logic [15:0] n);
    start_i     = 1'b1;
    seed_i      = seed;
    num_words_i = n;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!resp_valid_o && cyc < 200) begin
      tick();
      cyc++;
    end
    if (!resp_valid_o) check("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    logic [3:0] w;

    // Reset
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_chal", chal_o, 8'h00);
    check("rst_word", resp_word_o, 4'h0);
    check("rst_valid", resp_valid_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
`ifdef APUF_CRP_STABILITY_EN
    check("rst_unstable", unstable_cnt_o, 16'd0);
`endif

    // Test 1: seed 01, one word, ready high throughout.
    resp_ready_i = 1'b1;
    exp_q.push_back(4'hE);
    do_start(8'h01, 16'd1);
    check("t1_first_chal", chal_o, 8'h01);
    check("t1_busy", busy_o, 1'b1);
    wait_valid(cyc);
    check("t1_valid_latency", cyc, 20);
    tick();
    check("t1_valid_drop", resp_valid_o, 1'b0);
    check("t1_done", done_o, 1'b1);
    check("t1_chal_after", chal_o, 8'h1F);
    tick();
    check("t1_done_low", done_o, 1'b0);
    check("t1_busy_low", busy_o, 1'b0);
    check("t1_chal_kept", chal_o, 8'h1F);

    // Test 2: zero seed behaves as seed 01.
    exp_q.push_back(4'hE);
    do_start(8'h00, 16'd1);
    check("t2_first_chal", chal_o, 8'h01);
    wait_valid(cyc);
    check("t2_valid_latency", cyc, 20);
    repeat (2) tick();
    check("t2_idle", busy_o, 1'b0);

    // Test 3: two words, consumer stalls the first one for 10 cycles.
    mdl_chal = 8'h01;
    model_word(w);
    exp_q.push_back(w);
    model_word(w);
    exp_q.push_back(w);
    check("t3_model_w1", {28'd0, w}, 32'hB);
    hs_cnt = 0;
    resp_ready_i = 1'b0;
    do_start(8'h01, 16'd2);
    wait_valid(cyc);
    check("t3_valid_latency", cyc, 20);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_stall_valid", resp_valid_o, 1'b1);
      check("t3_stall_word", resp_word_o, 4'hE);
    end
    resp_ready_i = 1'b1;
    tick();
    check("t3_valid_drop", resp_valid_o, 1'b0);
    check("t3_busy_mid", busy_o, 1'b1);
    wait_valid(cyc);
    check("t3_second_latency", cyc, 20);
    tick();
    check("t3_done", done_o, 1'b1);
    tick();
    check("t3_handshakes", hs_cnt, 2);
    check("t3_idle", busy_o, 1'b0);

    // Test 4: zero words means no work.
    do_start(8'h01, 16'd0);
    check("t4_busy", busy_o, 1'b1);
    check("t4_done", done_o, 1'b1);
    check("t4_valid", resp_valid_o, 1'b0);
    tick();
    check("t4_busy_low", busy_o, 1'b0);
    check("t4_done_low", done_o, 1'b0);
    check("t4_valid_low", resp_valid_o, 1'b0);

`ifdef APUF_CRP_STABILITY_EN
    // Test 5: samples 1,0,1 in every vote window.
    exp_q.push_back(4'hF);
    puf_ovr = 1'b1;
    puf_drv = 1'b0;
    do_start(8'h01, 16'd1);
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 5; k++) begin
        puf_drv = (k == 2 || k == 4);
        tick();
      end
    end
    puf_ovr = 1'b0;
    check("t5_valid", resp_valid_o, 1'b1);
    check("t5_unstable", unstable_cnt_o, 16'd4);
    repeat (2) tick();
    check("t5_idle", busy_o, 1'b0);
`endif

    // Test 6: reset in the middle of a run, then start again.
    do_start(8'h01, 16'd1);
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_chal", chal_o, 8'h00);
    check("t6_word", resp_word_o, 4'h0);
    check("t6_valid", resp_valid_o, 1'b0);
    check("t6_busy", busy_o, 1'b0);
    check("t6_done", done_o, 1'b0);
    exp_q.push_back(4'hE);
    do_start(8'h01, 16'd1);
    wait_valid(cyc);
    check("t6_valid_latency", cyc, 20);
    repeat (2) tick();
    check("t6_idle", busy_o, 1'b0);

    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
